// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and default widths for the sequence detector datapath and its bench.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int SEQ_WORD_W = 8;
  localparam int SEQ_CNT_W  = 16;

endpackage

// File: rtl/seq_bit_serializer_shift_reg.sv
// Loadable shift register whose head bit sits at the top; bit order is fixed at load
// by storing the word either as-is or bit-reversed, so shifting is always leftward.
module seq_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic         msb_first,
  input  logic [W-1:0] d,
  output logic         q_bit
);

  logic [W-1:0] d_rev;
  logic [W-1:0] sreg_reg;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_rev
      assign d_rev[gi] = d[W-1-gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_reg <= '0;
    end else if (load) begin
      sreg_reg <= msb_first ? d : d_rev;
    end else if (shift) begin
      sreg_reg <= {sreg_reg[W-2:0], 1'b0};
    end
  end

  // The head flop drives the serial output directly, so a frozen register holds the line.
  assign q_bit = sreg_reg[W-1];

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector with a one-word holding register.
// Optional build macro SER_PARITY_EN appends an even-parity bit to every word.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WORD_W = SEQ_WORD_W,
  parameter int CNT_W  = SEQ_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              msb_first,
  input  logic              ser_en,
  output logic              input_seq,
  output logic              ser_valid,
  output logic              word_done,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int BCNT_W = $clog2(WORD_W + 1);
`ifdef SER_PARITY_EN
  localparam int FRAME_W = WORD_W + 1;
`else
  localparam int FRAME_W = WORD_W;
`endif
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(FRAME_W - 1);

  ser_state_t        state_reg, state_next;
  logic [WORD_W-1:0] hold_reg;
  logic              hold_full_reg;
  logic [BCNT_W-1:0] bcnt_reg, bcnt_next, bcnt_inc;
  logic              ser_valid_reg, ser_valid_next;
  logic              word_done_reg, word_done_next;
  logic [CNT_W-1:0]  words_sent_reg;
  logic              load, shift, word_end;
  logic [FRAME_W-1:0] frame_d;

`ifdef SER_PARITY_EN
  logic parity;
  assign parity  = ^hold_reg;
  // Parity is placed at whichever end is transmitted last for the chosen order.
  assign frame_d = msb_first ? {hold_reg, parity} : {parity, hold_reg};
`else
  assign frame_d = hold_reg;
`endif

  assign bcnt_inc = bcnt_reg + BCNT_W'(1);

  always_comb begin
    state_next     = state_reg;
    bcnt_next      = bcnt_reg;
    load           = 1'b0;
    shift          = 1'b0;
    word_end       = 1'b0;
    ser_valid_next = 1'b0;
    word_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hold_full_reg && ser_en) begin
          load           = 1'b1;
          bcnt_next      = '0;
          state_next     = SHIFT;
          ser_valid_next = 1'b1;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          ser_valid_next = 1'b1;
          if (bcnt_reg == LAST_IDX) begin
            word_end = 1'b1;
            if (hold_full_reg) begin
              load      = 1'b1;
              bcnt_next = '0;
            end else begin
              state_next     = IDLE;
              ser_valid_next = 1'b0;
            end
          end else begin
            shift          = 1'b1;
            bcnt_next      = bcnt_inc;
            word_done_next = (bcnt_inc == LAST_IDX);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      bcnt_reg       <= '0;
      ser_valid_reg  <= 1'b0;
      word_done_reg  <= 1'b0;
      words_sent_reg <= '0;
    end else begin
      state_reg      <= state_next;
      bcnt_reg       <= bcnt_next;
      ser_valid_reg  <= ser_valid_next;
      word_done_reg  <= word_done_next;
      if (word_end) begin
        words_sent_reg <= words_sent_reg + CNT_W'(1);
      end
    end
  end

  // A load only happens with the holding register full, which keeps din_ready low,
  // so an accept and a load can never land on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else if (load) begin
      hold_full_reg <= 1'b0;
    end else if (din_valid && !hold_full_reg) begin
      hold_reg      <= din;
      hold_full_reg <= 1'b1;
    end
  end

  seq_shift_reg #(
    .W(FRAME_W)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .msb_first(msb_first),
    .d        (frame_d),
    .q_bit    (input_seq)
  );

  assign din_ready  = !hold_full_reg;
  assign ser_valid  = ser_valid_reg;
  assign word_done  = word_done_reg;
  assign busy       = (state_reg == SHIFT);
  assign words_sent = words_sent_reg;

endmodule
